// File: rtl/ifu_pkg.sv
// Shared IFU fetch constants, fetch FSM encoding and the next-line PA helper.
package ifu_pkg;
  localparam int PA_W           = 34;
  localparam int LINE_W         = 256;
  localparam int INST_W         = 32;
  localparam int INSTS_PER_LINE = 8;
  localparam int OFF_W          = 5;
  localparam int SLOT_W         = 3;
  localparam int BASE_W         = PA_W - OFF_W;

  typedef enum logic [1:0] {REQ, WAIT, DRAIN} fstate_e;

  // Next sequential line; the line base wraps mod 2^BASE_W.
  function automatic logic [PA_W-1:0] line_next_pa(input logic [PA_W-1:0] pa);
    logic [BASE_W-1:0] nb;
    nb = pa[PA_W-1:OFF_W] + BASE_W'(1);
    return {nb, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/ifu_line_slicer.sv
// Line entry storage (1 or 2 entries) and the 8:1 instruction select.
module ifu_line_slicer
  import ifu_pkg::*;
#(
  parameter int NUM_ENT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic              wsel,
  input  logic [LINE_W-1:0] line,
  input  logic              rsel,
  input  logic [SLOT_W-1:0] ptr,
  output logic [INST_W-1:0] inst
);
  logic [NUM_ENT-1:0][INSTS_PER_LINE-1:0][INST_W-1:0] ent_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_q <= '0;
    end else begin
      for (int e = 0; e < NUM_ENT; e++)
        if (we && wsel == e[0]) ent_q[e] <= line;
    end
  end

  assign inst = ent_q[rsel][ptr];
endmodule

// File: rtl/ifu_fetch_line_buffer.sv
// Fetch line buffer: requests lines from the Icache, buffers them and feeds decode
// one 32b instruction per transfer. Define IFU_PREFETCH_EN for a ping-pong second entry.
module ifu_fetch_line_buffer
  import ifu_pkg::*;
#(
  parameter logic [PA_W-1:0] RESET_PA = '0
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              o_fetch_valid,
  input  logic              i_fetch_ready,
  output logic [PA_W-1:0]   o_fetch_pa_34,
  input  logic              i_line_valid,
  input  logic [LINE_W-1:0] i_line_32B,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst_32,
  output logic [PA_W-1:0]   o_inst_pa_34,
  input  logic              i_redirect,
  input  logic [PA_W-1:0]   i_redirect_pa_34,
  output logic              o_busy
);
`ifdef IFU_PREFETCH_EN
  localparam int NENT = 2;
`else
  localparam int NENT = 1;
`endif

  function automatic logic flip(input logic s);
    return (NENT == 2) ? ~s : s;
  endfunction

  fstate_e                      state_q, state_d;
  logic [PA_W-1:0]              r_pa, pa_d;
  logic                         r_drop, drop_d;
  logic                         r_live;
  logic [NENT-1:0]              vld_q, vld_d;
  logic                         rd_q, rd_d, wr_q, wr_d;
  logic [SLOT_W-1:0]            ptr_q, ptr_d;
  logic [NENT-1:0][BASE_W-1:0]  base_q;
  logic [NENT-1:0][SLOT_W-1:0]  off_q;
  logic                         fetch_xfer, inst_xfer, line_take;
  logic [PA_W-1:0]              redir_pa;

  // r_live keeps o_fetch_valid low while reset is asserted.
  assign o_fetch_valid = r_live && (state_q == REQ);
  assign o_fetch_pa_34 = r_pa;
  assign o_inst_valid  = vld_q[rd_q];
  assign o_inst_pa_34  = {base_q[rd_q], ptr_q, 2'b00};
  assign o_busy        = (state_q == WAIT) || (|vld_q);

  assign fetch_xfer = o_fetch_valid && i_fetch_ready;
  assign inst_xfer  = o_inst_valid && i_inst_ready;
  assign line_take  = (state_q == WAIT) && i_line_valid && !r_drop && !i_redirect;
  assign redir_pa   = i_redirect_pa_34 & ~PA_W'(3);

  // Drain side: entry valid bits, read/write entry selects, slot pointer.
  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    ptr_d = ptr_q;
    if (inst_xfer) begin
      ptr_d = ptr_q + SLOT_W'(1);
      if (ptr_q == '1) begin
        vld_d[rd_q] = 1'b0;
        rd_d        = flip(rd_q);
        ptr_d       = off_q[flip(rd_q)];
      end
    end
    if (line_take) begin
      vld_d[wr_q] = 1'b1;
      wr_d        = flip(wr_q);
      // Entry becomes the read entry this cycle: start at the fetched slot.
      if (wr_q == rd_d) ptr_d = r_pa[OFF_W-1:2];
    end
    if (i_redirect) begin
      vld_d = '0;
      rd_d  = 1'b0;
      wr_d  = 1'b0;
    end
  end

  // Fetch side: REQ requests when the write entry will be free, DRAIN idles until it is.
  always_comb begin
    state_d = state_q;
    pa_d    = r_pa;
    drop_d  = r_drop;
    unique case (state_q)
      REQ:   if (fetch_xfer) state_d = WAIT;
      WAIT:  if (i_line_valid) begin
               if (r_drop) begin
                 drop_d  = 1'b0;
                 state_d = REQ;
               end else begin
                 pa_d    = line_next_pa(r_pa);
                 state_d = vld_d[wr_d] ? DRAIN : REQ;
               end
             end
      DRAIN: if (!vld_d[wr_d]) state_d = REQ;
      default: state_d = REQ;
    endcase
    if (i_redirect) begin
      pa_d = redir_pa;
      // A line still owed by the Icache must be swallowed before re-requesting.
      if ((state_q == WAIT && !i_line_valid) || (state_q == REQ && fetch_xfer)) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= REQ;
      r_pa    <= RESET_PA;
      r_drop  <= 1'b0;
      r_live  <= 1'b0;
      vld_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ptr_q   <= '0;
      base_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      r_pa    <= pa_d;
      r_drop  <= drop_d;
      r_live  <= 1'b1;
      vld_q   <= vld_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ptr_q   <= ptr_d;
      if (line_take) begin
        base_q[wr_q] <= r_pa[PA_W-1:OFF_W];
        off_q[wr_q]  <= r_pa[OFF_W-1:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && i_line_valid)
      assert (state_q == WAIT)
        else $error("ifu_fetch_line_buffer: line returned with no request outstanding");
  end

  ifu_line_slicer #(.NUM_ENT(NENT)) u_slicer (
    .clk  (clk),
    .rstn (rstn),
    .we   (line_take),
    .wsel (wr_q),
    .line (i_line_32B),
    .rsel (rd_q),
    .ptr  (ptr_q),
    .inst (o_inst_32)
  );
endmodule

// File: tb/tb_ifu_fetch_line_buffer.sv
// Directed bench for ifu_fetch_line_buffer: fetch, drain, redirect, stall, wrap, prefetch.
module tb_ifu_fetch_line_buffer;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         o_fetch_valid, i_fetch_ready = 1'b0;
  logic [33:0]  o_fetch_pa_34;
  logic         i_line_valid = 1'b0;
  logic [255:0] i_line_32B = '0;
  logic         o_inst_valid, i_inst_ready = 1'b0;
  logic [31:0]  o_inst_32;
  logic [33:0]  o_inst_pa_34;
  logic         i_redirect = 1'b0;
  logic [33:0]  i_redirect_pa_34 = '0;
  logic         o_busy;
  int           total = 0;
  int           bad = 0;

  ifu_fetch_line_buffer dut (
    .clk              (clk),
    .rstn             (rstn),
    .o_fetch_valid    (o_fetch_valid),
    .i_fetch_ready    (i_fetch_ready),
    .o_fetch_pa_34    (o_fetch_pa_34),
    .i_line_valid     (i_line_valid),
    .i_line_32B       (i_line_32B),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst_32        (o_inst_32),
    .o_inst_pa_34     (o_inst_pa_34),
    .i_redirect       (i_redirect),
    .i_redirect_pa_34 (i_redirect_pa_34),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] tag);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = tag + 32'(k);
    return l;
  endfunction

  task automatic fetch_accept(input string tag, input logic [33:0] exp_pa);
    int n = 0;
    while (!o_fetch_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(o_fetch_valid), 64'(1));
    chk(tag, 64'(o_fetch_pa_34), 64'(exp_pa));
    i_fetch_ready = 1'b1;
    tick();
    i_fetch_ready = 1'b0;
  endtask

  task automatic send_line(input logic [31:0] tag);
    i_line_valid = 1'b1;
    i_line_32B   = mk_line(tag);
    tick();
    i_line_valid = 1'b0;
    i_line_32B   = '0;
  endtask

  task automatic redirect(input logic [33:0] pa);
    i_redirect       = 1'b1;
    i_redirect_pa_34 = pa;
    tick();
    i_redirect = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [31:0] wtag, input int k0, input int n,
                       input logic [33:0] base_pa);
    i_inst_ready = 1'b1;
    for (int k = k0; k < k0 + n; k++) begin
      chk({tag, "_ivalid"}, 64'(o_inst_valid), 64'(1));
      chk({tag, "_inst"}, 64'(o_inst_32), 64'(wtag + 32'(k)));
      chk({tag, "_ipa"}, 64'(o_inst_pa_34), 64'(base_pa + 34'(4 * k)));
      tick();
    end
    i_inst_ready = 1'b0;
  endtask

  task automatic chk_next_fetch(input string tag, input logic [33:0] pa);
    chk({tag, "_ivalid_low"}, 64'(o_inst_valid), 64'(0));
    chk({tag, "_fvalid"}, 64'(o_fetch_valid), 64'(1));
    chk({tag, "_fpa"}, 64'(o_fetch_pa_34), 64'(pa));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_fvalid", 64'(o_fetch_valid), 64'(0));
    chk("rst_ivalid", 64'(o_inst_valid), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_fpa", 64'(o_fetch_pa_34), 64'(0));
    rstn = 1'b1;
    tick();

    // 1: first line from RESET_PA, full drain, next sequential fetch
    fetch_accept("t1_fpa", 34'h0);
    chk("t1_wait_fvalid", 64'(o_fetch_valid), 64'(0));
    chk("t1_wait_busy", 64'(o_busy), 64'(1));
    tick();
    tick();
    send_line(32'h1000_0000);
    drain("t1", 32'h1000_0000, 0, 8, 34'h0);
    chk_next_fetch("t1_next", 34'h20);

    // 2: redirect mid-line (low PA bits ignored): only slots 6 and 7 issue
    redirect(34'h0_0000_001B);
    fetch_accept("t2_fpa", 34'h18);
    send_line(32'h2000_0000);
    drain("t2", 32'h2000_0000, 6, 2, 34'h0);
    chk_next_fetch("t2_next", 34'h20);

    // 3: redirect with a line in flight; the stale line is swallowed
    fetch_accept("t3_fpa0", 34'h20);
    redirect(34'h100);
    chk("t3_drop_fvalid", 64'(o_fetch_valid), 64'(0));
    chk("t3_drop_busy", 64'(o_busy), 64'(1));
    send_line(32'h3000_0000);
    chk_next_fetch("t3_stale", 34'h100);
    fetch_accept("t3_fpa1", 34'h100);
    chk("t3_single_req", 64'(o_fetch_valid), 64'(0));
    send_line(32'h4000_0000);

    // 4: decode stalls 5 cycles mid-line
    drain("t4a", 32'h4000_0000, 0, 3, 34'h100);
    for (int c = 0; c < 5; c++) begin
      chk("t4_stall_valid", 64'(o_inst_valid), 64'(1));
      chk("t4_stall_inst", 64'(o_inst_32), 64'(32'h4000_0003));
      chk("t4_stall_ipa", 64'(o_inst_pa_34), 64'(34'h10C));
      tick();
    end
    drain("t4b", 32'h4000_0000, 3, 5, 34'h100);
    chk_next_fetch("t4_next", 34'h120);

    // 5: top line of the PA space wraps to 0
    redirect(34'h3_FFFF_FFE0);
    fetch_accept("t5_fpa", 34'h3_FFFF_FFE0);
    send_line(32'h5000_0000);
    drain("t5", 32'h5000_0000, 0, 8, 34'h3_FFFF_FFE0);
    chk_next_fetch("t5_wrap", 34'h0);

    // redirect coinciding with an instruction transfer
    fetch_accept("tr_fpa", 34'h0);
    send_line(32'h6000_0000);
    drain("tr", 32'h6000_0000, 0, 1, 34'h0);
    chk("tr_inst1", 64'(o_inst_32), 64'(32'h6000_0001));
    i_inst_ready = 1'b1;
    redirect(34'h40);
    i_inst_ready = 1'b0;
    chk_next_fetch("tr_redir", 34'h40);
    chk("tr_busy", 64'(o_busy), 64'(0));

`ifdef IFU_PREFETCH_EN
    // 6: prefetch, Icache latency 3, decode always ready: 16 back-to-back insts
    fetch_accept("t6_fpa", 34'h40);
    tick();
    tick();
    send_line(32'h7000_0000);
    i_inst_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t6_ivalid", 64'(o_inst_valid), 64'(1));
      if (i < 8) begin
        chk("t6_inst", 64'(o_inst_32), 64'(32'h7000_0000 + 32'(i)));
        chk("t6_ipa", 64'(o_inst_pa_34), 64'(34'h40 + 34'(4 * i)));
      end else begin
        chk("t6_inst", 64'(o_inst_32), 64'(32'h8000_0000 + 32'(i - 8)));
        chk("t6_ipa", 64'(o_inst_pa_34), 64'(34'h60 + 34'(4 * (i - 8))));
      end
      if (i == 0) chk("t6_pref_fpa", 64'(o_fetch_pa_34), 64'(34'h60));
      i_fetch_ready = (i == 0) && o_fetch_valid;
      i_line_valid  = (i == 3);
      i_line_32B    = (i == 3) ? mk_line(32'h8000_0000) : '0;
      tick();
    end
    i_fetch_ready = 1'b0;
    i_line_valid  = 1'b0;
    i_inst_ready  = 1'b0;
    chk_next_fetch("t6_next", 34'h80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
